// File: rtl/hazard_stall_controller_if.sv
// Interface between ID decode / pipeline-enable logic and the hazard stall controller.
// master: decode side (drives instruction info, sees stall controls).
// slave:  the controller.
interface hazard_stall_if #(
    parameter int REG_W = 4
);
    logic             forwarding;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use_src2;
    logic             id_wb_en;
    logic             id_mem_read;
    logic             id_mem_acc;
    logic [REG_W-1:0] id_dest;
    logic             branch_taken;
    logic             mem_ready;
    logic             freeze_front;
    logic             bubble_ex;
    logic             freeze_all;
    logic             mem_timeout;
    logic [31:0]      stall_cycles;

    modport master (
        output forwarding, id_valid, id_src1, id_src2, id_use_src2, id_wb_en,
               id_mem_read, id_mem_acc, id_dest, branch_taken, mem_ready,
        input  freeze_front, bubble_ex, freeze_all, mem_timeout, stall_cycles
    );

    modport slave (
        input  forwarding, id_valid, id_src1, id_src2, id_use_src2, id_wb_en,
               id_mem_read, id_mem_acc, id_dest, branch_taken, mem_ready,
        output freeze_front, bubble_ex, freeze_all, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard / stall sequencer for a 5-stage pipeline.
// Shadows the EX and MEM destinations, detects RAW hazards for the ID
// instruction, and freezes the whole pipe while data memory is busy.
// Optional macro HAZARD_PERF_EN: builds a saturating stall_cycles counter
// (bubble_ex cycles); without it stall_cycles is tied to zero.
module hazard_stall_controller #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input logic          clk,
    input logic          rst,
    hazard_stall_if.slave hs
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
        logic             mem_acc;
    } slot_t;

    typedef enum logic {RUN, WAIT_MEM} state_t;

    slot_t            ex_q, mem_q;
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic             ex_hit, mem_hit, hz, freeze_all, bubble;

    // Source/destination match against each shadow slot
    always_comb begin
        ex_hit  = ex_q.valid & ex_q.wb_en &
                  ((ex_q.dest == hs.id_src1) | (hs.id_use_src2 & (ex_q.dest == hs.id_src2)));
        mem_hit = mem_q.valid & mem_q.wb_en &
                  ((mem_q.dest == hs.id_src1) | (hs.id_use_src2 & (mem_q.dest == hs.id_src2)));
    end

    // Hazard decision; a taken branch squashes ID so it never stalls
    always_comb begin
        hz = 1'b0;
        if (hs.forwarding)
            hz = hs.id_valid & ex_hit & ex_q.mem_read;
        else
            hz = hs.id_valid & (ex_hit | mem_hit);
        if (hs.branch_taken)
            hz = 1'b0;
        freeze_all = mem_q.valid & mem_q.mem_acc & ~hs.mem_ready;
        bubble     = hz & ~freeze_all;
    end

    assign hs.freeze_front = hz | freeze_all;
    assign hs.bubble_ex    = bubble;
    assign hs.freeze_all   = freeze_all;
    assign hs.mem_timeout  = timeout_q;

    // Shadow slots advance with the pipeline and hold while it is frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!freeze_all) begin
            if (bubble | hs.branch_taken | ~hs.id_valid)
                ex_q <= '0;
            else
                ex_q <= '{valid: 1'b1, dest: hs.id_dest, wb_en: hs.id_wb_en,
                          mem_read: hs.id_mem_read, mem_acc: hs.id_mem_acc};
            mem_q <= ex_q;
        end
    end

    // Memory-wait FSM with saturating wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze_all) begin
                        state    <= WAIT_MEM;
                        wait_cnt <= '0;
                    end
                end
                WAIT_MEM: begin
                    if (hs.mem_ready)
                        state <= RUN;
                    else if (wait_cnt != '1)
                        wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == CNT_W'(MEM_TIMEOUT))
                        timeout_q <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;

    // Count injected bubbles, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (bubble && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign hs.stall_cycles = stall_q;
`else
    assign hs.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. The driver pushes the expected
// {freeze_front, bubble_ex, freeze_all, mem_timeout, stall_cycles} for each
// cycle; the monitor pops and compares on the falling edge.
module tb_hazard_stall_controller;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [3:0]  flags;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   exp_sc = 0;

    hazard_stall_if #(.REG_W(4)) bus ();

    hazard_stall_controller #(.REG_W(4), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hs  (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare one expectation per cycle, away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if ({bus.freeze_front, bus.bubble_ex, bus.freeze_all, bus.mem_timeout} !== mon_e.flags ||
                bus.stall_cycles !== mon_e.sc) begin
                errors++;
                $display("FAIL %s: got ff/bx/fa/to=%b sc=%0d, expected %b sc=%0d", mon_e.nm,
                         {bus.freeze_front, bus.bubble_ex, bus.freeze_all, bus.mem_timeout},
                         bus.stall_cycles, mon_e.flags, mon_e.sc);
            end
        end
    end

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.id_src1     = 4'd0;
        bus.id_src2     = 4'd0;
        bus.id_use_src2 = 1'b0;
        bus.id_wb_en    = 1'b0;
        bus.id_mem_read = 1'b0;
        bus.id_mem_acc  = 1'b0;
        bus.id_dest     = 4'd0;
    endtask

    task automatic ins(input logic wb, input logic mr, input logic ma, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic u2);
        bus.id_valid    = 1'b1;
        bus.id_wb_en    = wb;
        bus.id_mem_read = mr;
        bus.id_mem_acc  = ma;
        bus.id_dest     = d;
        bus.id_src1     = s1;
        bus.id_src2     = s2;
        bus.id_use_src2 = u2;
    endtask

    // One clock of stimulus; f = expected {ff, bx, fa, to} for this cycle
    task automatic cyc(input string nm, input logic [3:0] f, input bit chk = 1'b1);
        exp_t e;
        if (chk) begin
            e.nm    = nm;
            e.flags = f;
            e.sc    = PERF ? 32'(exp_sc) : 32'd0;
            q.push_back(e);
        end
        if (rst) exp_sc = 0;
        else if (f[2]) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_pair(input logic [3:0] r);
        ins(1, 1, 1, r, 4'd0, 4'd0, 0);         cyc("perf_ldr", 4'b0000);
        ins(1, 0, 0, 4'd13, r, 4'd1, 1);        cyc("perf_use", 4'b1100);
        cyc("perf_go", 4'b0000);
        idle();                                  cyc("perf_idle", 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.forwarding   = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_ready    = 1'b1;
        cyc("rst0", 4'b0000, 0);
        cyc("rst1", 4'b0000, 0);
        rst = 1'b0;
        cyc("reset_state", 4'b0000);

        // load-use with forwarding: one stall
        bus.forwarding = 1'b1;
        ins(1, 1, 1, 4'd2, 4'd0, 4'd0, 0);      cyc("lu_ldr", 4'b0000);
        ins(1, 0, 0, 4'd3, 4'd2, 4'd1, 1);      cyc("lu_stall", 4'b1100);
        cyc("lu_go", 4'b0000);
        idle();                                  cyc("lu_i0", 4'b0000);
        cyc("lu_i1", 4'b0000);

        // ALU-ALU with forwarding: no stall
        ins(1, 0, 0, 4'd2, 4'd0, 4'd0, 0);      cyc("fw_add", 4'b0000);
        ins(1, 0, 0, 4'd4, 4'd2, 4'd2, 1);      cyc("fw_sub", 4'b0000);
        idle();                                  cyc("fw_i0", 4'b0000);
        cyc("fw_i1", 4'b0000);

        // no forwarding: EX match then MEM match
        bus.forwarding = 1'b0;
        ins(1, 0, 0, 4'd5, 4'd0, 4'd0, 0);      cyc("nf_add", 4'b0000);
        ins(1, 0, 0, 4'd6, 4'd5, 4'd0, 1);      cyc("nf_ex_hit", 4'b1100);
        cyc("nf_mem_hit", 4'b1100);
        cyc("nf_go", 4'b0000);
        idle();                                  cyc("nf_i0", 4'b0000);
        cyc("nf_i1", 4'b0000);

        // src2 not read: no stall even though src2 matches
        ins(1, 0, 0, 4'd5, 4'd0, 4'd0, 0);      cyc("u2_add", 4'b0000);
        ins(1, 0, 0, 4'd6, 4'd1, 4'd5, 0);      cyc("u2_orr", 4'b0000);
        idle();                                  cyc("u2_i0", 4'b0000);
        cyc("u2_i1", 4'b0000);

        // store stalls in MEM while a hazard waits in ID
        ins(0, 0, 1, 4'd0, 4'd1, 4'd1, 0);      cyc("ms_str", 4'b0000);
        ins(1, 0, 0, 4'd7, 4'd1, 4'd0, 0);      cyc("ms_add7", 4'b0000);
        ins(1, 0, 0, 4'd8, 4'd7, 4'd0, 0);
        bus.mem_ready = 1'b0;
        cyc("ms_w0", 4'b1010);
        cyc("ms_w1", 4'b1010);
        cyc("ms_w2", 4'b1010);
        bus.mem_ready = 1'b1;
        cyc("ms_rel_ex", 4'b1100);
        cyc("ms_rel_mem", 4'b1100);
        cyc("ms_go", 4'b0000);
        idle();                                  cyc("ms_i0", 4'b0000);
        cyc("ms_i1", 4'b0000);

        // long memory wait trips the sticky timeout (MEM_TIMEOUT=4)
        ins(1, 1, 1, 4'd9, 4'd0, 4'd0, 0);      cyc("to_ldr", 4'b0000);
        idle();                                  cyc("to_i", 4'b0000);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) cyc("to_wait", 4'b1010);
        cyc("to_set0", 4'b1011);
        cyc("to_set1", 4'b1011);
        bus.mem_ready = 1'b1;
        cyc("to_rel", 4'b0001);
        cyc("to_sticky0", 4'b0001);
        cyc("to_sticky1", 4'b0001);

        // branch in the same cycle as a load-use hazard
        bus.forwarding = 1'b1;
        ins(1, 1, 1, 4'd10, 4'd0, 4'd0, 0);     cyc("br_ldr10", 4'b0001);
        ins(1, 1, 1, 4'd11, 4'd10, 4'd0, 0);
        bus.branch_taken = 1'b1;
        cyc("br_flush", 4'b0001);
        bus.branch_taken = 1'b0;
        ins(1, 0, 0, 4'd12, 4'd11, 4'd0, 0);    cyc("br_ex_inval", 4'b0001);
        idle();                                  cyc("br_i0", 4'b0001);
        cyc("br_i1", 4'b0001);

        // reset while waiting on memory
        ins(0, 0, 1, 4'd0, 4'd0, 4'd0, 0);      cyc("rw_str", 4'b0001);
        idle();                                  cyc("rw_i", 4'b0001);
        bus.mem_ready = 1'b0;
        cyc("rw_w0", 4'b1011);
        cyc("rw_w1", 4'b1011);
        rst = 1'b1;
        cyc("rw_rst", 4'b1011);
        rst = 1'b0;
        cyc("rw_after0", 4'b0000);
        cyc("rw_after1", 4'b0000);
        bus.mem_ready = 1'b1;

        // three load-use pairs
        load_use_pair(4'd2);
        load_use_pair(4'd4);
        load_use_pair(4'd6);
        cyc("perf_final", 4'b0000);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
